stream_calc_controller: RTL and testbench

Parametrised successor to the calculator controller. It streams operand pairs from SRAM, computes add or subtract per word, packs two results per write word internally, and writes them back to a bounded output region. It adds a start/done handshake, configurable read latency, odd-count flush, range-error detection and a sticky overflow flag. It sits between the calculator SRAM and the host/testbench sequencer and replaces the external result buffer.

---
 rtl/stream_calc_controller.sv | 187 ++++++++++++++++++
 tb/tb_stream_calc_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_calc_controller.sv
// stream_calc_controller: streams operand pairs from SRAM, adds or subtracts
// each pair, packs two results per word and writes them to a bounded region.
module stream_calc_controller #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned ADDR_W        = 10,
   parameter int unsigned MEM_WORD_SIZE = 64,
   parameter int unsigned RD_LAT        = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic                     mode_i,
   input  logic [ADDR_W-1:0]        read_start_addr,
   input  logic [ADDR_W-1:0]        read_end_addr,
   input  logic [ADDR_W-1:0]        write_start_addr,
   input  logic [ADDR_W-1:0]        write_end_addr,
   output logic                     read,
   output logic [ADDR_W-1:0]        r_addr,
   input  logic [MEM_WORD_SIZE-1:0] r_data,
   output logic                     write,
   output logic [ADDR_W-1:0]        w_addr,
   output logic [MEM_WORD_SIZE-1:0] w_data,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     ovf_o,
   output logic                     err_o
);

   localparam int unsigned CNT_W     = 2;
   localparam int unsigned WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_CALC,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                   state;
   state_t                   state_nxt;

   logic                     mode_q;
   logic [ADDR_W-1:0]        rd_ptr;
   logic [ADDR_W-1:0]        rd_end;
   logic [ADDR_W-1:0]        wr_ptr;
   logic [ADDR_W-1:0]        wr_end;
   logic [MEM_WORD_SIZE-1:0] pack;
   logic                     half;
   logic                     rd_done;
   logic [CNT_W-1:0]         wait_cnt;

   logic                     range_bad_c;
   logic                     last_op_c;
   logic                     wr_full_c;
   logic [DATA_W-1:0]        op_a_c;
   logic [DATA_W-1:0]        op_b_c;
   logic [DATA_W:0]          sum_c;

   // Region checks, operand split and the arithmetic with carry/borrow in the MSB
   assign range_bad_c = (read_end_addr < read_start_addr) ||
                        (write_end_addr < write_start_addr);
   assign last_op_c   = (rd_ptr == rd_end);
   assign wr_full_c   = (wr_ptr == wr_end);
   assign op_a_c      = r_data[DATA_W-1:0];
   assign op_b_c      = r_data[MEM_WORD_SIZE-1:DATA_W];
   assign sum_c       = mode_q ? ({1'b0, op_a_c} - {1'b0, op_b_c})
                               : ({1'b0, op_a_c} + {1'b0, op_b_c});

   // Addresses and write data come straight from their registers
   assign r_addr = rd_ptr;
   assign w_addr = wr_ptr;
   assign w_data = pack;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded strobes
   always_comb begin
      state_nxt = state;
      read      = 1'b0;
      write     = 1'b0;
      busy_o    = 1'b1;
      done_o    = 1'b0;
      case (state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               state_nxt = range_bad_c ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            read      = 1'b1;
            state_nxt = (RD_LAT > 1) ? S_WAIT : S_CALC;
         end
         S_WAIT: begin
            if (wait_cnt == CNT_W'(WAIT_LAST)) begin
               state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            state_nxt = (half || last_op_c) ? S_WRITE : S_READ;
         end
         S_WRITE: begin
            write     = 1'b1;
            state_nxt = (rd_done || wr_full_c) ? S_DONE : S_READ;
         end
         S_DONE: begin
            done_o    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Job registers: latched config, pointers, pack buffer, flags
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q   <= 1'b0;
         rd_ptr   <= '0;
         rd_end   <= '0;
         wr_ptr   <= '0;
         wr_end   <= '0;
         pack     <= '0;
         half     <= 1'b0;
         rd_done  <= 1'b0;
         wait_cnt <= '0;
         ovf_o    <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  mode_q  <= mode_i;
                  rd_ptr  <= read_start_addr;
                  rd_end  <= read_end_addr;
                  wr_ptr  <= write_start_addr;
                  wr_end  <= write_end_addr;
                  pack    <= '0;
                  half    <= 1'b0;
                  rd_done <= 1'b0;
                  ovf_o   <= 1'b0;
                  err_o   <= range_bad_c;
               end
            end
            S_READ: begin
               wait_cnt <= '0;
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + CNT_W'(1);
            end
            S_CALC: begin
               if (half) begin
                  pack[MEM_WORD_SIZE-1:DATA_W] <= sum_c[DATA_W-1:0];
               end else begin
                  pack[DATA_W-1:0] <= sum_c[DATA_W-1:0];
               end
               if (sum_c[DATA_W]) begin
                  ovf_o <= 1'b1;
               end
               if (last_op_c) begin
                  rd_done <= 1'b1;
               end
               half   <= ~half;
               rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            S_WRITE: begin
               pack   <= '0;
               half   <= 1'b0;
               wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_calc_controller.sv
// Bench for stream_calc_controller: two instances (RD_LAT=1 and RD_LAT=3)
// share the stimulus; each has its own SRAM model and expected-write queue.
module tb_stream_calc_controller;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 10;
   localparam int unsigned MW = 64;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [MW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          mode;
   logic [AW-1:0] rs, re, ws, we;

   logic          rd0, wr0, busy0, done0, ovf0, err0;
   logic          rd1, wr1, busy1, done1, ovf1, err1;
   logic [AW-1:0] ra0, wa0, ra1, wa1;
   logic [MW-1:0] rdat0, wdat0, rdat1, wdat1;

   logic [MW-1:0] mem [2][1024];
   logic [MW-1:0] opmem [1024];
   logic [MW-1:0] pipe3 [3];

   wr_t q0[$];
   wr_t q1[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rd_cnt[2], wr_cnt[2], done_cnt[2], overlap[2];
   int first_rd[2], last_wr[2], done_cyc[2];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   stream_calc_controller #(.DATA_W(DW), .ADDR_W(AW), .MEM_WORD_SIZE(MW), .RD_LAT(1)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
      .read_start_addr(rs), .read_end_addr(re),
      .write_start_addr(ws), .write_end_addr(we),
      .read(rd0), .r_addr(ra0), .r_data(rdat0),
      .write(wr0), .w_addr(wa0), .w_data(wdat0),
      .busy_o(busy0), .done_o(done0), .ovf_o(ovf0), .err_o(err0)
   );

   stream_calc_controller #(.DATA_W(DW), .ADDR_W(AW), .MEM_WORD_SIZE(MW), .RD_LAT(3)) u_dut_lat3 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
      .read_start_addr(rs), .read_end_addr(re),
      .write_start_addr(ws), .write_end_addr(we),
      .read(rd1), .r_addr(ra1), .r_data(rdat1),
      .write(wr1), .w_addr(wa1), .w_data(wdat1),
      .busy_o(busy1), .done_o(done1), .ovf_o(ovf1), .err_o(err1)
   );

   // SRAM read paths: data valid only RD_LAT cycles after the strobe, zero otherwise
   always @(posedge clk) begin
      rdat0    <= rd0 ? mem[0][ra0] : '0;
      pipe3[0] <= rd1 ? mem[1][ra1] : '0;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign rdat1 = pipe3[2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Per-instance observer: counts strobes, commits writes, scores them against the queue
   task automatic mon(input int i, input logic rd, input logic wr, input logic dn,
                      input logic [AW-1:0] wa, input logic [MW-1:0] wd);
      wr_t e;
      bit  have;
      if (rd) begin
         if (rd_cnt[i] == 0) first_rd[i] = cyc;
         rd_cnt[i]++;
      end
      if (wr) begin
         wr_cnt[i]++;
         last_wr[i]  = cyc;
         mem[i][wa]  = wd;
         have        = 1'b0;
         if (i == 0 && q0.size() > 0) begin
            e = q0.pop_front(); have = 1'b1;
         end else if (i == 1 && q1.size() > 0) begin
            e = q1.pop_front(); have = 1'b1;
         end
         if (have) begin
            check($sformatf("wr_addr%0d", i), 64'(wa), 64'(e.addr));
            check($sformatf("wr_data%0d", i), wd, e.data);
         end
      end
      if (rd && wr) overlap[i]++;
      if (dn) begin
         done_cnt[i]++;
         done_cyc[i] = cyc;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, rd0, wr0, done0, wa0, wdat0);
         mon(1, rd1, wr1, done1, wa1, wdat1);
      end
   end

   task automatic load(input int addr, input logic [DW-1:0] b, input logic [DW-1:0] a);
      opmem[addr]  = {b, a};
      mem[0][addr] = {b, a};
      mem[1][addr] = {b, a};
   endtask

   // Reference behaviour of one job; pushes expected writes for both instances
   task automatic model(input bit md, input logic [AW-1:0] a_s, input logic [AW-1:0] a_e,
                        input logic [AW-1:0] w_s, input logic [AW-1:0] w_e,
                        output int nrd, output int nwr, output bit ovf, output bit err);
      logic [AW-1:0] p, wp;
      logic [MW-1:0] pk;
      logic [DW-1:0] a, b, r;
      bit            hi;
      wr_t           e;
      nrd = 0; nwr = 0; ovf = 1'b0;
      err = (a_e < a_s) || (w_e < w_s);
      if (!err) begin
         p = a_s; wp = w_s; pk = '0; hi = 1'b0;
         for (int guard = 0; guard < 1024; guard++) begin
            a = opmem[p][DW-1:0];
            b = opmem[p][MW-1:DW];
            nrd++;
            if (md) begin
               r = a - b;
               if (a < b) ovf = 1'b1;
            end else begin
               r = a + b;
               if (r < a) ovf = 1'b1;
            end
            if (hi) pk[MW-1:DW] = r;
            else    pk[DW-1:0]  = r;
            if (hi || p == a_e) begin
               e.addr = wp; e.data = pk;
               q0.push_back(e); q1.push_back(e);
               nwr++;
               if (p == a_e || wp == w_e) break;
               wp = wp + AW'(1); pk = '0; hi = 1'b0;
            end else begin
               hi = 1'b1;
            end
            p = p + AW'(1);
         end
      end
   endtask

   task automatic run_job(input string name, input bit md,
                          input logic [AW-1:0] a_s, input logic [AW-1:0] a_e,
                          input logic [AW-1:0] w_s, input logic [AW-1:0] w_e);
      int nrd, nwr, sc, exp_done;
      int lat[2];
      bit ovf, err, ok;
      logic obs_ovf, obs_err, obs_busy;
      lat[0] = 1; lat[1] = 3;
      q0.delete(); q1.delete();
      model(md, a_s, a_e, w_s, w_e, nrd, nwr, ovf, err);
      for (int i = 0; i < 2; i++) begin
         rd_cnt[i] = 0; wr_cnt[i] = 0; done_cnt[i] = 0; overlap[i] = 0;
         first_rd[i] = -1; last_wr[i] = -1; done_cyc[i] = -1;
      end
      @(negedge clk);
      mode = md; rs = a_s; re = a_e; ws = w_s; we = w_e; start = 1'b1;
      sc = cyc;
      @(negedge clk);
      if (!err) begin
         // inputs change and start stays high while busy: must be ignored
         mode = ~md; rs = AW'($urandom); re = AW'($urandom);
         ws = AW'($urandom); we = AW'($urandom);
         @(negedge clk);
         @(negedge clk);
      end
      start = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (done_cnt[0] > 0 && done_cnt[1] > 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      check({name, "_done_seen"}, 64'(ok), 64'(1));
      repeat (3) @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         obs_ovf  = (i == 0) ? ovf0  : ovf1;
         obs_err  = (i == 0) ? err0  : err1;
         obs_busy = (i == 0) ? busy0 : busy1;
         check($sformatf("%s_reads%0d",   name, i), 64'(rd_cnt[i]),   64'(nrd));
         check($sformatf("%s_writes%0d",  name, i), 64'(wr_cnt[i]),   64'(nwr));
         check($sformatf("%s_donecnt%0d", name, i), 64'(done_cnt[i]), 64'(1));
         check($sformatf("%s_overlap%0d", name, i), 64'(overlap[i]),  64'(0));
         check($sformatf("%s_leftover%0d", name, i),
               64'((i == 0) ? q0.size() : q1.size()), 64'(0));
         check($sformatf("%s_ovf%0d",  name, i), 64'(obs_ovf),  64'(ovf));
         check($sformatf("%s_err%0d",  name, i), 64'(obs_err),  64'(err));
         check($sformatf("%s_busy%0d", name, i), 64'(obs_busy), 64'(0));
         exp_done = err ? sc + 1 : sc + 1 + nrd * (1 + lat[i]) + nwr;
         check($sformatf("%s_donecyc%0d", name, i), 64'(done_cyc[i]), 64'(exp_done));
         if (!err) begin
            check($sformatf("%s_firstrd%0d", name, i), 64'(first_rd[i]), 64'(sc + 1));
            check($sformatf("%s_lastwr%0d",  name, i), 64'(done_cyc[i]), 64'(last_wr[i] + 1));
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_ctl"},   64'({rd0, wr0, busy0, done0, ovf0, err0,
                                  rd1, wr1, busy1, done1, ovf1, err1}), 64'(0));
      check({tag, "_addr"},  64'({ra0, wa0, ra1, wa1}), 64'(0));
      check({tag, "_wdat0"}, wdat0, 64'(0));
      check({tag, "_wdat1"}, wdat1, 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int sc, wsum;
      rst_n = 1'b0; start = 1'b0; mode = 1'b0;
      rs = '0; re = '0; ws = '0; we = '0;
      for (int k = 0; k < 1024; k++) load(k, '0, '0);
      load(0, 32'd1, 32'd2);
      load(1, 32'd3, 32'd4);
      load(2, 32'd5, 32'd6);
      load(3, 32'd7, 32'd8);
      load(4, 32'd2, 32'd1);
      for (int k = 16; k < 24; k++) load(k, $urandom, $urandom);
      repeat (3) @(negedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // add, even count
      run_job("add", 1'b0, 10'd0, 10'd3, 10'd8, 10'd9);
      check("add_m8_l1",  mem[0][8], {32'd7,  32'd3});
      check("add_m9_l1",  mem[0][9], {32'd15, 32'd11});
      check("add_m8_l3",  mem[1][8], {32'd7,  32'd3});
      check("add_m9_l3",  mem[1][9], {32'd15, 32'd11});

      // odd count flush
      run_job("odd", 1'b0, 10'd0, 10'd2, 10'd8, 10'd9);
      check("odd_m9_l1", mem[0][9], {32'd0, 32'd11});
      check("odd_m9_l3", mem[1][9], {32'd0, 32'd11});

      // subtract with borrow, sticky overflow
      run_job("sub", 1'b1, 10'd4, 10'd4, 10'd10, 10'd10);
      check("sub_m10_l1", mem[0][10], {32'd0, 32'hFFFF_FFFF});
      check("sub_m10_l3", mem[1][10], {32'd0, 32'hFFFF_FFFF});
      repeat (5) @(negedge clk);
      #1;
      check("sub_ovf_sticky", 64'({ovf0, ovf1}), 64'(2'b11));

      // write-region limit
      run_job("wlim", 1'b0, 10'd0, 10'd3, 10'd8, 10'd8);

      // range errors
      run_job("rerr", 1'b0, 10'd3, 10'd1, 10'd8, 10'd9);
      repeat (4) @(negedge clk);
      #1;
      check("rerr_err_held", 64'({err0, err1}), 64'(2'b11));
      run_job("werr", 1'b1, 10'd0, 10'd3, 10'd9, 10'd8);

      // random operands, both modes
      run_job("rsub", 1'b1, 10'd16, 10'd22, 10'd24, 10'd30);
      run_job("radd", 1'b0, 10'd16, 10'd23, 10'd24, 10'd25);

      // reset during a write aborts the job
      q0.delete(); q1.delete();
      @(negedge clk);
      mode = 1'b0; rs = 10'd0; re = 10'd3; ws = 10'd40; we = 10'd41; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (wr0) break;
      end
      check("midrst_write_seen", 64'(wr0), 64'(1));
      wsum = wr_cnt[0] + wr_cnt[1];
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      check("midrst_no_write", 64'(wr_cnt[0] + wr_cnt[1]), 64'(wsum));
      run_job("postrst", 1'b0, 10'd0, 10'd3, 10'd8, 10'd9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
